// File: rtl/binary_morph3x3_pkg.sv
// Raster timing shared by the VGA timing generator, this filter and the centroid stage.
// Also holds the mask "white" code and a wrap-around coordinate decrement.
package pkg_vga_timing;

    localparam int H_ACT   = 640;
    localparam int V_ACT   = 480;
    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;

    localparam logic [11:0] WHITE = 12'hfff;

    typedef logic [9:0] coord_t;

    // v-1, wrapping 0 to top (top is the last legal coordinate, TOTAL-1)
    function automatic coord_t wrap_dec(input coord_t v, input coord_t top);
        return (v == '0) ? top : v - coord_t'(1);
    endfunction

endpackage

// File: rtl/binary_morph3x3_line_buffer_1b.sv
// One-bit line store: synchronous read-before-write on a single address.
// Storage is deliberately not reset.
module line_buffer_1b #(
    parameter int DEPTH = 640
) (
    input  logic                       vga_clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic                       din,
    output logic                       dout
);

    logic mem [DEPTH];

    always_ff @(posedge vga_clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/binary_morph3x3.sv
// 3x3 erode/dilate of the 1-bit hand mask carried on img_data, streamed in raster order.
// Output pixel and its window-centre coordinates appear together three clocks after the sample.
module binary_morph3x3 #(
    parameter int H_ACT   = pkg_vga_timing::H_ACT,
    parameter int V_ACT   = pkg_vga_timing::V_ACT,
    parameter int H_TOTAL = pkg_vga_timing::H_TOTAL,
    parameter int V_TOTAL = pkg_vga_timing::V_TOTAL,
    parameter int OP      = 0
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic [11:0] img_data,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    output logic [11:0] img_data_o,
    output logic [9:0]  pixel_x_o,
    output logic [9:0]  pixel_y_o
);

    import pkg_vga_timing::WHITE;
    import pkg_vga_timing::coord_t;
    import pkg_vga_timing::wrap_dec;

    localparam int     AW    = $clog2(H_ACT);
    localparam coord_t HA    = coord_t'(H_ACT);
    localparam coord_t VA    = coord_t'(V_ACT);
    localparam coord_t HA_M1 = coord_t'(H_ACT - 1);
    localparam coord_t VA_M1 = coord_t'(V_ACT - 1);
    localparam coord_t HT_M1 = coord_t'(H_TOTAL - 1);
    localparam coord_t VT_M1 = coord_t'(V_TOTAL - 1);

    logic          active;
    logic          bin;
    logic [AW-1:0] lb_addr;
    coord_t        cx;
    coord_t        cy;
    coord_t        cy_up;
    logic          inner;

    assign active  = (pixel_x < HA) && (pixel_y < VA);
    assign bin     = active && (img_data == WHITE);
    assign lb_addr = active ? pixel_x[AW-1:0] : '0;

    // Sample (x,y) completes the window centred one column left and one row up.
    always_comb begin
        cx    = wrap_dec(pixel_x, HT_M1);
        cy_up = wrap_dec(pixel_y, VT_M1);
        cy    = (pixel_x == '0) ? wrap_dec(cy_up, VT_M1) : cy_up;
        inner = (cx != '0) && (cx < HA_M1) && (cy != '0) && (cy < VA_M1);
    end

    logic          lb0_q;
    logic          lb1_q;

    logic          act_d1_reg;
    logic          cur_d1_reg;
    logic [AW-1:0] addr_d1_reg;
    coord_t        cx_d1_reg;
    coord_t        cy_d1_reg;
    logic          inner_d1_reg;

    logic          act_d2_reg;
    logic          cur_d2_reg;
    logic          up1_d2_reg;
    coord_t        cx_d2_reg;
    coord_t        cy_d2_reg;
    logic          inner_d2_reg;

    logic          frame_ok_reg;

    line_buffer_1b #(.DEPTH(H_ACT)) u_lb0 (
        .vga_clk (vga_clk),
        .we      (active),
        .addr    (lb_addr),
        .din     (bin),
        .dout    (lb0_q)
    );

    // lb1 runs one clock behind lb0 so it can store what lb0 just returned for the same column.
    line_buffer_1b #(.DEPTH(H_ACT)) u_lb1 (
        .vga_clk (vga_clk),
        .we      (act_d1_reg),
        .addr    (addr_d1_reg),
        .din     (lb0_q),
        .dout    (lb1_q)
    );

    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            act_d1_reg   <= 1'b0;
            cur_d1_reg   <= 1'b0;
            addr_d1_reg  <= '0;
            cx_d1_reg    <= '0;
            cy_d1_reg    <= '0;
            inner_d1_reg <= 1'b0;
            act_d2_reg   <= 1'b0;
            cur_d2_reg   <= 1'b0;
            up1_d2_reg   <= 1'b0;
            cx_d2_reg    <= '0;
            cy_d2_reg    <= '0;
            inner_d2_reg <= 1'b0;
        end else begin
            act_d1_reg   <= active;
            cur_d1_reg   <= bin;
            addr_d1_reg  <= lb_addr;
            cx_d1_reg    <= cx;
            cy_d1_reg    <= cy;
            inner_d1_reg <= inner;
            act_d2_reg   <= act_d1_reg;
            cur_d2_reg   <= cur_d1_reg;
            up1_d2_reg   <= act_d1_reg & lb0_q;
            cx_d2_reg    <= cx_d1_reg;
            cy_d2_reg    <= cy_d1_reg;
            inner_d2_reg <= inner_d1_reg;
        end
    end

    // Only a frame start seen since reset makes the line buffers trustworthy.
    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            frame_ok_reg <= 1'b0;
        end else if ((pixel_x == '0) && (pixel_y == '0)) begin
            frame_ok_reg <= 1'b1;
        end
    end

    // Newest column, row 0 = y-2, row 1 = y-1, row 2 = y; blanking shifts in zeros.
    logic [2:0] col;
    logic [8:0] window;

    assign col[0] = act_d2_reg & lb1_q;
    assign col[1] = up1_d2_reg;
    assign col[2] = cur_d2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_row
            logic [1:0] hist_reg;

            always_ff @(posedge vga_clk) begin
                if (!rst_n) begin
                    hist_reg <= '0;
                end else begin
                    hist_reg <= {hist_reg[0], col[gi]};
                end
            end

            // Two older columns plus the live one form this row's 3-bit slice.
            assign window[gi*3 +: 3] = {hist_reg, col[gi]};
        end
    endgenerate

    logic win_hit;
    assign win_hit = (OP == 0) ? (&window) : (|window);

    always_ff @(posedge vga_clk) begin
        if (!rst_n) begin
            img_data_o <= '0;
            pixel_x_o  <= '0;
            pixel_y_o  <= '0;
        end else begin
            img_data_o <= (frame_ok_reg && inner_d2_reg && win_hit) ? WHITE : 12'h000;
            pixel_x_o  <= cx_d2_reg;
            pixel_y_o  <= cy_d2_reg;
        end
    end

endmodule

// File: tb/tb_binary_morph3x3.sv
// Directed bench: two small-raster instances (erode, dilate) share one stimulus stream;
// a default-timing instance checks the full-size coordinate wrap.
`timescale 1ns/1ps
module tb_binary_morph3x3;

    localparam int HA = 32;
    localparam int VA = 24;
    localparam int HT = 40;
    localparam int VT = 30;
    localparam int INNER = (HA - 2) * (VA - 2);

    logic        vga_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [11:0] img_s   = '0;
    logic [9:0]  px_s    = '0;
    logic [9:0]  py_s    = '0;
    logic [11:0] img_f   = '0;
    logic [9:0]  px_f    = '0;
    logic [9:0]  py_f    = '0;

    logic [11:0] oe_img, od_img, of_img;
    logic [9:0]  oe_x, oe_y, od_x, od_y, of_x, of_y;

    always #5 vga_clk = ~vga_clk;

    binary_morph3x3 #(.H_ACT(HA), .V_ACT(VA), .H_TOTAL(HT), .V_TOTAL(VT), .OP(0)) dut_e (
        .vga_clk(vga_clk), .rst_n(rst_n), .img_data(img_s), .pixel_x(px_s), .pixel_y(py_s),
        .img_data_o(oe_img), .pixel_x_o(oe_x), .pixel_y_o(oe_y)
    );

    binary_morph3x3 #(.H_ACT(HA), .V_ACT(VA), .H_TOTAL(HT), .V_TOTAL(VT), .OP(1)) dut_d (
        .vga_clk(vga_clk), .rst_n(rst_n), .img_data(img_s), .pixel_x(px_s), .pixel_y(py_s),
        .img_data_o(od_img), .pixel_x_o(od_x), .pixel_y_o(od_y)
    );

    binary_morph3x3 dut_f (
        .vga_clk(vga_clk), .rst_n(rst_n), .img_data(img_f), .pixel_x(px_f), .pixel_y(py_f),
        .img_data_o(of_img), .pixel_x_o(of_x), .pixel_y_o(of_y)
    );

    int checks = 0;
    int errors = 0;

    // Samples in flight: index 2 is the one whose result is visible now.
    int dl_x[3];
    int dl_y[3];
    int dl_scene[3];
    bit dl_fok[3];
    bit dl_valid[3] = '{0, 0, 0};
    bit fok = 1'b0;

    int    st_bad_e, st_bad_d, st_bad_xy;
    int    st_white_e, st_white_d, st_white_after_rst;
    string st_first;

    // Scenes: 0 all white, 1 single pixel at (16,12), 2 block x5..7 y8..10 on 12'h7ff,
    // 3 black active area with white blanking.
    function automatic logic [11:0] img_of(input int scene, input int x, input int y);
        bit act;
        act = (x < HA) && (y < VA);
        case (scene)
            0:       return 12'hfff;
            1:       return (x == 16 && y == 12) ? 12'hfff : 12'h000;
            2:       return (x >= 5 && x <= 7 && y >= 8 && y <= 10) ? 12'hfff :
                            (act ? 12'h7ff : 12'h000);
            default: return act ? 12'h000 : 12'hfff;
        endcase
    endfunction

    function automatic bit exp_white(input int op, input int scene, input int cx, input int cy,
                                     input bit ok);
        bit inner;
        inner = ok && cx >= 1 && cx <= HA - 2 && cy >= 1 && cy <= VA - 2;
        case (scene)
            0:       return inner;
            1:       return inner && op == 1 && cx >= 15 && cx <= 17 && cy >= 11 && cy <= 13;
            2:       return (op == 0) ? (inner && cx == 6 && cy == 9)
                                      : (inner && cx >= 4 && cx <= 8 && cy >= 7 && cy <= 11);
            default: return 1'b0;
        endcase
    endfunction

    // Drives one full raster frame into the small instances and tallies what comes out.
    task automatic drive_frame(input int scene, input bit do_rst, input int rx, input int ry);
        int ex, ey;
        bit we, wd, rst_now, rst_seen;
        st_bad_e = 0; st_bad_d = 0; st_bad_xy = 0;
        st_white_e = 0; st_white_d = 0; st_white_after_rst = 0;
        st_first = "";
        rst_seen = 1'b0;
        for (int y = 0; y < VT; y++) begin
            for (int x = 0; x < HT; x++) begin
                @(negedge vga_clk);
                if (dl_valid[2]) begin
                    ex = dl_x[2];
                    ey = (dl_y[2] == 0) ? VT - 1 : dl_y[2] - 1;
                    if (ex == 0) begin
                        ex = HT - 1;
                        ey = (ey == 0) ? VT - 1 : ey - 1;
                    end else begin
                        ex = ex - 1;
                    end
                    we = exp_white(0, dl_scene[2], ex, ey, dl_fok[2]);
                    wd = exp_white(1, dl_scene[2], ex, ey, dl_fok[2]);
                    if (int'(oe_x) != ex || int'(oe_y) != ey || int'(od_x) != ex || int'(od_y) != ey)
                        st_bad_xy++;
                    if (oe_img !== (we ? 12'hfff : 12'h000)) begin
                        if (st_bad_e == 0 && st_bad_d == 0)
                            st_first = $sformatf("erode at (%0d,%0d) got %h", ex, ey, oe_img);
                        st_bad_e++;
                    end
                    if (od_img !== (wd ? 12'hfff : 12'h000)) begin
                        if (st_bad_e == 0 && st_bad_d == 0)
                            st_first = $sformatf("dilate at (%0d,%0d) got %h", ex, ey, od_img);
                        st_bad_d++;
                    end
                end
                if (oe_img == 12'hfff) st_white_e++;
                if (od_img == 12'hfff) st_white_d++;
                if (rst_seen && (oe_img != 12'h000 || od_img != 12'h000)) st_white_after_rst++;

                rst_now = do_rst && x == rx && y == ry;
                rst_n = !rst_now;
                px_s  = 10'(x);
                py_s  = 10'(y);
                img_s = img_of(scene, x, y);
                if (rst_now) begin
                    fok = 1'b0;
                    rst_seen = 1'b1;
                    dl_valid = '{0, 0, 0};
                end else if (x == 0 && y == 0) begin
                    fok = 1'b1;
                end
                dl_x[2] = dl_x[1]; dl_y[2] = dl_y[1]; dl_scene[2] = dl_scene[1];
                dl_fok[2] = dl_fok[1]; dl_valid[2] = dl_valid[1];
                dl_x[1] = dl_x[0]; dl_y[1] = dl_y[0]; dl_scene[1] = dl_scene[0];
                dl_fok[1] = dl_fok[0]; dl_valid[1] = dl_valid[0];
                dl_x[0] = x; dl_y[0] = y; dl_scene[0] = scene;
                dl_fok[0] = fok; dl_valid[0] = !rst_now;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        img_s = 12'hfff; px_s = 10'd3; py_s = 10'd3;
        img_f = 12'hfff; px_f = 10'd7; py_f = 10'd7;
        repeat (3) @(negedge vga_clk);
        checks++; if (oe_img !== 12'h000) begin errors++; $display("FAIL reset erode img: got %h, expected 000", oe_img); end
        checks++; if (oe_x !== 10'd0 || oe_y !== 10'd0) begin errors++; $display("FAIL reset erode xy: got (%0d,%0d), expected (0,0)", oe_x, oe_y); end
        checks++; if (od_img !== 12'h000) begin errors++; $display("FAIL reset dilate img: got %h, expected 000", od_img); end
        checks++; if (od_x !== 10'd0 || od_y !== 10'd0) begin errors++; $display("FAIL reset dilate xy: got (%0d,%0d), expected (0,0)", od_x, od_y); end
        checks++; if (of_img !== 12'h000) begin errors++; $display("FAIL reset full img: got %h, expected 000", of_img); end
        checks++; if (of_x !== 10'd0 || of_y !== 10'd0) begin errors++; $display("FAIL reset full xy: got (%0d,%0d), expected (0,0)", of_x, of_y); end
        img_s = 12'h000;
        img_f = 12'h000;
        rst_n = 1'b1;
    endtask

    // Full 640x480 / 800x525 timing: centre wrap across line and frame boundaries.
    task automatic test_coord_full();
        int sx[9] = '{0, 5, 0, 1, 639, 799, 700, 700, 700};
        int sy[9] = '{0, 10, 1, 0, 479, 524, 500, 500, 500};
        int ex[6] = '{799, 4, 799, 0, 638, 798};
        int ey[6] = '{523, 9, 524, 524, 478, 523};
        for (int i = 0; i < 9; i++) begin
            @(negedge vga_clk);
            if (i >= 3) begin
                checks++;
                if (int'(of_x) != ex[i-3]) begin
                    errors++;
                    $display("FAIL coord_full x for input (%0d,%0d): got %0d, expected %0d", sx[i-3], sy[i-3], of_x, ex[i-3]);
                end
                checks++;
                if (int'(of_y) != ey[i-3]) begin
                    errors++;
                    $display("FAIL coord_full y for input (%0d,%0d): got %0d, expected %0d", sx[i-3], sy[i-3], of_y, ey[i-3]);
                end
            end
            px_f = 10'(sx[i]);
            py_f = 10'(sy[i]);
        end
    endtask

    task automatic test_all_white();
        drive_frame(0, 1'b0, 0, 0);
        checks++; if (st_bad_xy !== 0) begin errors++; $display("FAIL all_white coords: %0d misaligned outputs, expected 0", st_bad_xy); end
        checks++; if (st_bad_e !== 0 || st_bad_d !== 0) begin errors++; $display("FAIL all_white pixels: erode %0d dilate %0d wrong, expected 0 (%s)", st_bad_e, st_bad_d, st_first); end
        checks++; if (st_white_e !== INNER) begin errors++; $display("FAIL all_white erode count: got %0d, expected %0d", st_white_e, INNER); end
        checks++; if (st_white_d !== INNER) begin errors++; $display("FAIL all_white dilate count: got %0d, expected %0d", st_white_d, INNER); end
    endtask

    task automatic test_single_pixel();
        drive_frame(1, 1'b0, 0, 0);
        checks++; if (st_bad_e !== 0 || st_bad_d !== 0) begin errors++; $display("FAIL single_pixel pixels: erode %0d dilate %0d wrong, expected 0 (%s)", st_bad_e, st_bad_d, st_first); end
        checks++; if (st_white_e !== 0) begin errors++; $display("FAIL single_pixel erode count: got %0d, expected 0", st_white_e); end
        checks++; if (st_white_d !== 9) begin errors++; $display("FAIL single_pixel dilate count: got %0d, expected 9", st_white_d); end
    endtask

    task automatic test_block();
        drive_frame(2, 1'b0, 0, 0);
        checks++; if (st_bad_e !== 0 || st_bad_d !== 0) begin errors++; $display("FAIL block pixels: erode %0d dilate %0d wrong, expected 0 (%s)", st_bad_e, st_bad_d, st_first); end
        checks++; if (st_white_e !== 1) begin errors++; $display("FAIL block erode count: got %0d, expected 1", st_white_e); end
        checks++; if (st_white_d !== 25) begin errors++; $display("FAIL block dilate count: got %0d, expected 25", st_white_d); end
        checks++; if (st_bad_xy !== 0) begin errors++; $display("FAIL block coords: %0d misaligned outputs, expected 0", st_bad_xy); end
    endtask

    task automatic test_blank_white();
        for (int f = 0; f < 2; f++) begin
            drive_frame(3, 1'b0, 0, 0);
            checks++;
            if (st_white_e !== 0 || st_white_d !== 0) begin
                errors++;
                $display("FAIL blank_white frame %0d: erode %0d dilate %0d white, expected 0", f, st_white_e, st_white_d);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        drive_frame(0, 1'b1, 12, 10);
        checks++; if (st_white_after_rst !== 0) begin errors++; $display("FAIL reset_mid_frame: got %0d white after reset, expected 0", st_white_after_rst); end
        checks++; if (st_bad_e !== 0 || st_bad_d !== 0) begin errors++; $display("FAIL reset_mid_frame pixels: erode %0d dilate %0d wrong, expected 0 (%s)", st_bad_e, st_bad_d, st_first); end
        drive_frame(0, 1'b0, 0, 0);
        checks++; if (st_white_e !== INNER || st_white_d !== INNER) begin errors++; $display("FAIL reset_next_frame count: erode %0d dilate %0d, expected %0d", st_white_e, st_white_d, INNER); end
        checks++; if (st_bad_xy !== 0 || st_bad_e !== 0 || st_bad_d !== 0) begin errors++; $display("FAIL reset_next_frame: xy %0d erode %0d dilate %0d wrong, expected 0", st_bad_xy, st_bad_e, st_bad_d); end
    endtask

    initial begin
        test_reset();
        test_coord_full();
        test_all_white();
        test_single_pixel();
        test_block();
        test_blank_white();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
